// File: rtl/core_decode.sv
// RV32I decode stage: turns the if_id register into the id_ex register and
// detects load-use hazards, stalling fetch for one bubble.
package core_decode_pkg;
  typedef logic [31:0] addr_t;

  typedef struct packed {
    logic [31:0] inst;
    addr_t       pc;
    logic        valid;
  } if_id_t;

  typedef struct packed {
    logic        valid;
    addr_t       pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] rs1_val;
    logic [31:0] rs2_val;
    logic [31:0] imm;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [6:0]  opcode;
    logic        reg_write;
    logic        mem_read;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        alu_src_imm;
    logic        illegal;
  } id_ex_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
endpackage

module core_decode
  import core_decode_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int HAZARD_CHECK = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            exec_rdy,
  input  logic            flush,
  input  if_id_t          if_id,
  input  logic [XLEN-1:0] rf_rs1_data,
  input  logic [XLEN-1:0] rf_rs2_data,
  output logic [4:0]      rf_rs1_addr,
  output logic [4:0]      rf_rs2_addr,
  output logic            rdy,
  output id_ex_t          id_ex
);

  id_ex_t      id_ex_q, id_ex_d;
  id_ex_t      dec;
  logic        use_rs1, use_rs2;
  logic        hazard;
  logic [31:0] inst;

  assign inst        = if_id.inst;
  assign rf_rs1_addr = inst[19:15];
  assign rf_rs2_addr = inst[24:20];

  function automatic logic [31:0] imm_i(input logic [31:0] i);
    return {{20{i[31]}}, i[31:20]};
  endfunction

  function automatic logic [31:0] imm_s(input logic [31:0] i);
    return {{20{i[31]}}, i[31:25], i[11:7]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] i);
    return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] i);
    return {i[31:12], 12'b0};
  endfunction

  function automatic logic [31:0] imm_j(input logic [31:0] i);
    return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
  endfunction

  // Bubble: keep the datapath fields, kill validity and every side effect.
  function automatic id_ex_t kill_ctrl(input id_ex_t e);
    id_ex_t r;
    r             = e;
    r.valid       = 1'b0;
    r.reg_write   = 1'b0;
    r.mem_read    = 1'b0;
    r.mem_write   = 1'b0;
    r.branch      = 1'b0;
    r.jump        = 1'b0;
    r.alu_src_imm = 1'b0;
    r.illegal     = 1'b0;
    return r;
  endfunction

  always_comb begin
    dec         = '0;
    use_rs1     = 1'b0;
    use_rs2     = 1'b0;
    dec.pc      = if_id.pc;
    dec.rs1     = inst[19:15];
    dec.rs2     = inst[24:20];
    dec.rd      = inst[11:7];
    dec.rs1_val = rf_rs1_data[31:0];
    dec.rs2_val = rf_rs2_data[31:0];
    dec.funct3  = inst[14:12];
    dec.funct7  = inst[31:25];
    dec.opcode  = inst[6:0];
    unique case (inst[6:0])
      OPC_LOAD: begin
        dec.imm = imm_i(inst); use_rs1 = 1'b1;
        dec.mem_read = 1'b1; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
      end
      OPC_STORE: begin
        dec.imm = imm_s(inst); use_rs1 = 1'b1; use_rs2 = 1'b1; dec.rd = 5'd0;
        dec.mem_write = 1'b1; dec.alu_src_imm = 1'b1;
      end
      OPC_BRANCH: begin
        dec.imm = imm_b(inst); use_rs1 = 1'b1; use_rs2 = 1'b1; dec.rd = 5'd0;
        dec.branch = 1'b1;
      end
      OPC_JAL: begin
        dec.imm = imm_j(inst); dec.jump = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_JALR: begin
        dec.imm = imm_i(inst); use_rs1 = 1'b1;
        dec.jump = 1'b1; dec.reg_write = 1'b1;
      end
      OPC_OPIMM: begin
        dec.imm = imm_i(inst); use_rs1 = 1'b1;
        dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        dec.imm = imm_u(inst); dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
      end
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; dec.reg_write = 1'b1;
      end
      default: dec.illegal = 1'b1;
    endcase
    if (dec.rd == 5'd0) dec.reg_write = 1'b0;
  end

  assign hazard = (HAZARD_CHECK != 0) && id_ex_q.valid && id_ex_q.mem_read &&
                  if_id.valid && (id_ex_q.rd != 5'd0) &&
                  ((use_rs1 && (inst[19:15] == id_ex_q.rd)) ||
                   (use_rs2 && (inst[24:20] == id_ex_q.rd)));

  assign rdy = exec_rdy && !hazard;

  always_comb begin
    id_ex_d = id_ex_q;
    if (flush) begin
      id_ex_d = kill_ctrl(id_ex_q);
    end else if (!exec_rdy) begin
      id_ex_d = id_ex_q;
    end else if (hazard) begin
      id_ex_d = kill_ctrl(id_ex_q);
    end else begin
      id_ex_d       = dec;
      id_ex_d.valid = en && if_id.valid;
    end
  end

  // id_ex pipeline register
  always_ff @(posedge clk) begin
    if (!rst) id_ex_q <= '0;
    else      id_ex_q <= id_ex_d;
  end

  assign id_ex = id_ex_q;

endmodule

// File: tb/tb_core_decode.sv
// Directed bench for core_decode: hand-decoded RV32I vectors, load-use stall,
// backpressure, flush, illegal opcode and mid-stall reset.
module tb_core_decode;
  import core_decode_pkg::*;

  logic        clk = 1'b0;
  logic        rst, en, exec_rdy, flush;
  if_id_t      if_id;
  logic [31:0] rf_rs1_data, rf_rs2_data;
  logic [4:0]  rf_rs1_addr, rf_rs2_addr;
  logic        rdy;
  id_ex_t      id_ex;

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [31:0] I_ADDI  = 32'hFFF00293; // addi x5,x0,-1
  localparam logic [31:0] I_LW6   = 32'h0000A303; // lw   x6,0(x1)
  localparam logic [31:0] I_ADD   = 32'h002303B3; // add  x7,x6,x2
  localparam logic [31:0] I_LW0   = 32'h0000A003; // lw   x0,0(x1)
  localparam logic [31:0] I_ADD00 = 32'h000003B3; // add  x7,x0,x0
  localparam logic [31:0] I_BEQ   = 32'h00208463; // beq  x1,x2,+8
  localparam logic [31:0] I_SW    = 32'h0020A623; // sw   x2,12(x1)
  localparam logic [31:0] I_JAL   = 32'hFFDFF0EF; // jal  x1,-4
  localparam logic [31:0] I_LUI   = 32'h123451B7; // lui  x3,0x12345

  always #5 clk = ~clk;

  // Register file stand-in: each register reads back a recognisable value.
  assign rf_rs1_data = 32'h1000 + {27'd0, rf_rs1_addr};
  assign rf_rs2_data = 32'h2000 + {27'd0, rf_rs2_addr};

  core_decode #(.XLEN(32), .HAZARD_CHECK(1)) dut (
    .clk(clk), .rst(rst), .en(en), .exec_rdy(exec_rdy), .flush(flush),
    .if_id(if_id), .rf_rs1_data(rf_rs1_data), .rf_rs2_data(rf_rs2_data),
    .rf_rs1_addr(rf_rs1_addr), .rf_rs2_addr(rf_rs2_addr),
    .rdy(rdy), .id_ex(id_ex)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic drive(input logic [31:0] inst, input logic v);
    if_id.inst  = inst;
    if_id.pc    = 32'h100;
    if_id.valid = v;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; exec_rdy = 1'b1; flush = 1'b0;
    if_id = '0;
    #2;
    tick(); tick();
    chk("reset_all_zero", {31'd0, |id_ex}, 32'd0);
    rst = 1'b1;

    // ADDI x5,x0,-1
    drive(I_ADDI, 1'b1);
    chk("addi_rdy", {31'd0, rdy}, 32'd1);
    chk("rs1_addr", {27'd0, rf_rs1_addr}, 32'd0);
    tick();
    chk("addi_valid", {31'd0, id_ex.valid}, 32'd1);
    chk("addi_imm", id_ex.imm, 32'hFFFFFFFF);
    chk("addi_rd", {27'd0, id_ex.rd}, 32'd5);
    chk("addi_regw", {31'd0, id_ex.reg_write}, 32'd1);
    chk("addi_aluimm", {31'd0, id_ex.alu_src_imm}, 32'd1);
    chk("addi_pc", id_ex.pc, 32'h100);
    chk("addi_rs1val", id_ex.rs1_val, 32'h1000);

    // Load-use: LW x6 then ADD x7,x6,x2
    drive(I_LW6, 1'b1);
    chk("lw_rdy", {31'd0, rdy}, 32'd1);
    tick();
    chk("lw_memrd", {31'd0, id_ex.mem_read}, 32'd1);
    chk("lw_rd", {27'd0, id_ex.rd}, 32'd6);
    drive(I_ADD, 1'b1);
    chk("lu_stall_rdy", {31'd0, rdy}, 32'd0);
    tick();
    chk("lu_bubble_valid", {31'd0, id_ex.valid}, 32'd0);
    chk("lu_bubble_memrd", {31'd0, id_ex.mem_read}, 32'd0);
    chk("lu_resume_rdy", {31'd0, rdy}, 32'd1);
    tick();
    chk("add_valid", {31'd0, id_ex.valid}, 32'd1);
    chk("add_rs1", {27'd0, id_ex.rs1}, 32'd6);
    chk("add_rs1val", id_ex.rs1_val, 32'h1006);
    chk("add_rs2val", id_ex.rs2_val, 32'h2002);
    chk("add_rd", {27'd0, id_ex.rd}, 32'd7);
    chk("add_aluimm", {31'd0, id_ex.alu_src_imm}, 32'd0);
    chk("add_imm", id_ex.imm, 32'd0);

    // LW x0 then use of x0: no stall
    drive(I_LW0, 1'b1);
    tick();
    chk("lw0_regw", {31'd0, id_ex.reg_write}, 32'd0);
    drive(I_ADD00, 1'b1);
    chk("lw0_nostall", {31'd0, rdy}, 32'd1);
    tick();
    chk("lw0_use_valid", {31'd0, id_ex.valid}, 32'd1);

    // BEQ then 3 cycles of backpressure
    drive(I_BEQ, 1'b1);
    tick();
    exec_rdy = 1'b0;
    drive(I_ADDI, 1'b1);
    for (int c = 0; c < 3; c++) begin
      chk("bp_rdy", {31'd0, rdy}, 32'd0);
      tick();
      chk("bp_imm", id_ex.imm, 32'd8);
      chk("bp_rd", {27'd0, id_ex.rd}, 32'd0);
      chk("bp_branch", {31'd0, id_ex.branch}, 32'd1);
      chk("bp_valid", {31'd0, id_ex.valid}, 32'd1);
    end
    exec_rdy = 1'b1;
    #1;
    tick();
    chk("bp_release_branch", {31'd0, id_ex.branch}, 32'd0);
    chk("bp_release_imm", id_ex.imm, 32'hFFFFFFFF);

    // Immediate formats
    drive(I_SW, 1'b1);
    tick();
    chk("sw_imm", id_ex.imm, 32'd12);
    chk("sw_rd", {27'd0, id_ex.rd}, 32'd0);
    chk("sw_memwr", {31'd0, id_ex.mem_write}, 32'd1);
    drive(I_JAL, 1'b1);
    tick();
    chk("jal_imm", id_ex.imm, 32'hFFFFFFFC);
    chk("jal_jump", {31'd0, id_ex.jump}, 32'd1);
    chk("jal_regw", {31'd0, id_ex.reg_write}, 32'd1);
    drive(I_LUI, 1'b1);
    tick();
    chk("lui_imm", id_ex.imm, 32'h12345000);

    // Flush with a pending hazard, then with a plain valid instruction
    drive(I_LW6, 1'b1);
    tick();
    flush = 1'b1;
    drive(I_ADD, 1'b1);
    chk("flush_hz_rdy", {31'd0, rdy}, 32'd0);
    tick();
    chk("flush_hz_valid", {31'd0, id_ex.valid}, 32'd0);
    chk("flush_hz_memrd", {31'd0, id_ex.mem_read}, 32'd0);
    drive(I_ADDI, 1'b1);
    tick();
    chk("flush_valid", {31'd0, id_ex.valid}, 32'd0);
    chk("flush_regw", {31'd0, id_ex.reg_write}, 32'd0);
    flush = 1'b0;

    // Illegal all-zero instruction
    drive(32'h0, 1'b1);
    tick();
    chk("ill_illegal", {31'd0, id_ex.illegal}, 32'd1);
    chk("ill_valid", {31'd0, id_ex.valid}, 32'd1);
    chk("ill_flags", {29'd0, id_ex.reg_write, id_ex.mem_read, id_ex.mem_write}, 32'd0);

    // Invalid input and disabled stage
    drive(I_ADDI, 1'b0);
    chk("inv_rdy", {31'd0, rdy}, 32'd1);
    tick();
    chk("inv_valid", {31'd0, id_ex.valid}, 32'd0);
    en = 1'b0;
    drive(I_ADDI, 1'b1);
    tick();
    chk("en0_valid", {31'd0, id_ex.valid}, 32'd0);
    en = 1'b1;

    // Reset asserted mid-stall
    drive(I_LW6, 1'b1);
    tick();
    drive(I_ADD, 1'b1);
    chk("rst_stall_rdy", {31'd0, rdy}, 32'd0);
    rst = 1'b0;
    tick();
    chk("rst_mid_zero", {31'd0, |id_ex}, 32'd0);
    rst = 1'b1;
    #1;
    chk("rst_no_stale_hz", {31'd0, rdy}, 32'd1);
    tick();
    chk("rst_resume_valid", {31'd0, id_ex.valid}, 32'd1);
    chk("rst_resume_rs1", {27'd0, id_ex.rs1}, 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/core_decode.md
Name: core_decode

Overview:
RV32I decode stage, directly downstream of the fetch stage. It consumes the `if_id` pipeline register and drives `decode_rdy` back to fetch. It reads the register file and produces the `id_ex` pipeline register for execute. It owns load-use hazard detection: a one-cycle bubble with upstream backpressure. It also squashes its output on a branch-redirect flush from execute.

Parameters:
- `XLEN`, 32, datapath width; must equal the width of `addr_t`.
- `HAZARD_CHECK`, 1, 1 enables load-use stall logic; 0 makes `hazard` constant 0.

Ports:
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  reset; synchronous, active-low (sampled on posedge `clk`, asserted when 0).
- `en`  in  1  stage enable; when 0 no new valid instruction is issued.
- `exec_rdy`  in  1  execute can accept `id_ex` this cycle.
- `flush`  in  1  branch/jump redirect from execute; kills the current decode.
- `if_id`  in  `if_id_t`  fields: `inst`[31:0], `pc`[`addr_t`], `valid`.
- `rf_rs1_data`  in  `XLEN`  register file read data, port 1 (combinational read).
- `rf_rs2_data`  in  `XLEN`  register file read data, port 2.
- `rf_rs1_addr`  out  5  equals `if_id.inst`[19:15].
- `rf_rs2_addr`  out  5  equals `if_id.inst`[24:20].
- `rdy`  out  1  connects to fetch `decode_rdy`; asserted when `if_id` is consumed this cycle.
- `id_ex`  out  `id_ex_t`  fields: `valid`, `pc`, `rs1`[4:0], `rs2`[4:0], `rd`[4:0], `rs1_val`, `rs2_val`, `imm`[31:0], `funct3`[2:0], `funct7`[6:0], `opcode`[6:0], `reg_write`, `mem_read`, `mem_write`, `branch`, `jump`, `alu_src_imm`, `illegal`.

Behaviour:
- Reset (`rst`=0 at posedge): every `id_ex` field is cleared to 0. `rdy` is combinational and has no reset value of its own.
- `hazard` is asserted when all of the following hold:
  - `HAZARD_CHECK`, `id_ex.valid`, `id_ex.mem_read` and `if_id.valid` are all 1;
  - `id_ex.rd` != 0;
  - ((rs1 is used and rs1 == `id_ex.rd`) or (rs2 is used and rs2 == `id_ex.rd`)).
- Register use by instruction type:
  - rs1 is used by R, I, S, B, JALR.
  - rs2 is used by R, S, B.
  - LUI, AUIPC, JAL use neither.
- `rdy` = `exec_rdy` && !`hazard`.
- Posedge priority, highest first:
  1. `rst`=0: clear all fields.
  2. `flush`=1: `id_ex.valid` <= 0 and all control flags <= 0, regardless of `exec_rdy` or `hazard`.
  3. `exec_rdy`=0: hold `id_ex` unchanged.
  4. `hazard`=1: insert a bubble (`id_ex.valid` <= 0, control flags <= 0). `if_id` is held by fetch because `rdy`=0.
  5. Otherwise: load the decoded fields, with `id_ex.valid` <= `en` && `if_id.valid`.
- Latency: 1 cycle from `if_id` to `id_ex`. A load-use pair costs exactly 1 bubble. After the bubble, `id_ex.valid`=0, so `hazard` drops and the consumer issues the next cycle.
- `rs1_val` and `rs2_val` are captured from `rf_*_data` in the same cycle the instruction is consumed. Write-back bypass is the register file's responsibility.
- Immediates, all sign-extended from `inst`[31]:
  - I: `inst`[31:20]
  - S: {[31:25],[11:7]}
  - B: {[31],[7],[30:25],[11:8],0}
  - U: {[31:12],12'b0}
  - J: {[31],[19:12],[20],[30:21],0}
  - R type: `imm`=0.
- Control flags by opcode:
  - LOAD: `mem_read`, `reg_write`, `alu_src_imm`.
  - STORE: `mem_write`, `alu_src_imm`.
  - BRANCH: `branch`.
  - JAL, JALR: `jump`, `reg_write`.
  - OP-IMM, LUI, AUIPC: `reg_write`, `alu_src_imm`.
  - OP: `reg_write`.
- S and B types force `rd` to 0.
- `reg_write` is forced to 0 when `rd` == 0.
- Unknown opcode, or `inst`[1:0] != 2'b11: `illegal`=1 with all other control flags 0. `valid` follows the normal rule so execute can trap.
- Invalid input (`if_id.valid`=0) with `exec_rdy`=1: `id_ex.valid` <= 0; `rdy` stays 1.
- `flush` during a hazard: `flush` wins and `rdy` is still !`hazard` && `exec_rdy`. Fetch is responsible for discarding wrong-path `if_id`.
- Reset deasserted mid-stall: the stage resumes from the cleared state with no stale hazard.

Test Plan:
- ADDI x5,x0,-1 (0xFFF00293), `exec_rdy`=1 -> next cycle:
  - `id_ex.valid`=1, `imm`=0xFFFFFFFF, `rd`=5, `reg_write`=1, `alu_src_imm`=1.
  - `rdy`=1 throughout.
- LW x6,0(x1) followed by ADD x7,x6,x2:
  - `rdy`=0 for exactly 1 cycle and `id_ex` shows 1 bubble (`valid`=0).
  - ADD appears the following cycle with `rs1`=6.
  - LW x0 followed by a use of x0 -> no stall.
- BEQ (0x00208463), then hold `exec_rdy`=0 for 3 cycles:
  - `id_ex` holds with `imm`=8, `rd`=0, `branch`=1 and `rdy`=0.
  - Releasing `exec_rdy` advances the pipeline.
- `flush`=1 concurrent with a valid `if_id` and with a pending hazard -> next cycle `id_ex.valid`=0 and `mem_read`=0.
- `inst`=0x00000000 -> `illegal`=1, `valid`=1, `reg_write`=`mem_read`=`mem_write`=0.
- Drive `rst`=0 for 1 cycle while `id_ex.valid`=1 -> all `id_ex` fields 0 at the next edge; normal decode resumes after `rst`=1.
